cdb_arbiter: RTL

//  Shares one common data bus (CDB) between N_SRC result producers (default ALU0, ALU1, LSB).

---
 rtl/cdb_arbiter_pkg.sv | 20 ++
 rtl/cdb_src_fifo.sv | 50 +++++
 rtl/cdb_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths, source indices and CDB entry packing
package cdb_arbiter_pkg;

   localparam int CDB_ROB_POS_W = 4;
   localparam int CDB_DATA_W    = 32;
   localparam int CDB_ADDR_W    = 32;

   localparam int CDB_SRC_ALU0  = 0;
   localparam int CDB_SRC_ALU1  = 1;
   localparam int CDB_SRC_LSB   = 2;

   // Field order matches the flat {rob_pos, val, jump, pc} vector stored in the source FIFOs
   typedef struct packed {
      logic [CDB_ROB_POS_W-1:0] rob_pos;
      logic [CDB_DATA_W-1:0]    val;
      logic                     jump;
      logic [CDB_ADDR_W-1:0]    pc;
   } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-producer skid FIFO feeding the CDB scheduler
module cdb_src_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 69
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Storage is not reset; validity is tracked entirely by count
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin scheduler sharing one registered CDB among N_SRC producers
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_SRC      = 3,
   parameter int FIFO_DEPTH = 2,
   parameter int ROB_POS_W  = CDB_ROB_POS_W,
   parameter int DATA_W     = CDB_DATA_W,
   parameter int ADDR_W     = CDB_ADDR_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rdy,
   input  logic                       rollback,
   input  logic [N_SRC-1:0]           src_valid,
   output logic [N_SRC-1:0]           src_ready,
   input  logic [N_SRC*ROB_POS_W-1:0] src_rob_pos,
   input  logic [N_SRC*DATA_W-1:0]    src_val,
   input  logic [N_SRC-1:0]           src_jump,
   input  logic [N_SRC*ADDR_W-1:0]    src_pc,
   output logic                       cdb_valid,
   output logic [ROB_POS_W-1:0]       cdb_rob_pos,
   output logic [DATA_W-1:0]          cdb_val,
   output logic                       cdb_jump,
   output logic [ADDR_W-1:0]          cdb_pc,
   output logic [$clog2(N_SRC)-1:0]   cdb_src,
   output logic                       busy
);

   localparam int SRC_W   = $clog2(N_SRC);
   localparam int ENTRY_W = ROB_POS_W + DATA_W + 1 + ADDR_W;

   logic [N_SRC-1:0]   fifo_full;
   logic [N_SRC-1:0]   fifo_empty;
   logic [N_SRC-1:0]   push;
   logic [ENTRY_W-1:0] fifo_head [N_SRC];
   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W-1:0]   win_idx;
   logic [SRC_W-1:0]   rr_next;
   logic               win_found;
   logic               run;
   logic               flush;

   // rdy low freezes everything; rollback outranks both push and pop
   assign run   = rdy & ~rollback;
   assign flush = rdy & rollback;
   assign push  = {N_SRC{run}} & src_valid & ~fifo_full;

   function automatic logic [SRC_W:0] rr_pick(input logic [N_SRC-1:0] req,
                                              input logic [SRC_W-1:0] ptr);
      logic             found;
      logic [SRC_W-1:0] idx;
      logic [SRC_W-1:0] cand;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N_SRC; k++) begin
         cand = SRC_W'((int'(ptr) + k) % N_SRC);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      {win_found, win_idx} = rr_pick(~fifo_empty, rr_ptr);
      rr_next = (win_idx == SRC_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
   end

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      logic [ENTRY_W-1:0] wdata;
      logic               pop;

      assign wdata = {src_rob_pos[i*ROB_POS_W +: ROB_POS_W],
                      src_val[i*DATA_W +: DATA_W],
                      src_jump[i],
                      src_pc[i*ADDR_W +: ADDR_W]};
      assign pop   = run & win_found & (win_idx == SRC_W'(i));

      cdb_src_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (ENTRY_W)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .flush (flush),
         .push  (push[i]),
         .pop   (pop),
         .wdata (wdata),
         .full  (fifo_full[i]),
         .empty (fifo_empty[i]),
         .head  (fifo_head[i])
      );
   end

   // Data fields hold their last broadcast when no source wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb_valid   <= 1'b0;
         cdb_rob_pos <= '0;
         cdb_val     <= '0;
         cdb_jump    <= 1'b0;
         cdb_pc      <= '0;
         cdb_src     <= '0;
         rr_ptr      <= '0;
      end else if (rdy) begin
         if (rollback) begin
            cdb_valid <= 1'b0;
            rr_ptr    <= '0;
         end else if (win_found) begin
            cdb_valid <= 1'b1;
            {cdb_rob_pos, cdb_val, cdb_jump, cdb_pc} <= fifo_head[win_idx];
            cdb_src   <= win_idx;
            rr_ptr    <= rr_next;
         end else begin
            cdb_valid <= 1'b0;
         end
      end
   end

   assign src_ready = ~fifo_full;
   assign busy      = ~(&fifo_empty) | cdb_valid;

endmodule
